// File: rtl/program_loader.sv
// program_loader
// Writer side of the instruction memory. Receives a framed byte stream over a
// valid/ready handshake, assembles instructions (high byte first), writes them
// sequentially from address 0 and verifies an XOR checksum. The cpu is held in
// reset until a frame has loaded with a matching checksum.
//
// Frame: N (count), 2*N payload bytes, checksum (XOR of header and payload).
//
// Ports:
//   clk           clock, all logic on posedge
//   rst           synchronous active-low reset
//   in_data       stream byte
//   in_valid      in_data is valid
//   in_ready      loader accepts a byte this cycle (decoded from state only)
//   start         reload request, honoured only in DONE or ERROR
//   mem_data      instruction to write (holds last written value)
//   mem_addr      write address (holds last written value)
//   mem_en_write  one-cycle write strobe
//   cpu_rst       active-high cpu reset, 1 while not DONE
//   done          program loaded and checksum matched
//   error         checksum mismatch
//   loaded_count  instructions written in the current/last frame
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for header byte N
// HI      | waiting for instruction high byte
// LO      | waiting for instruction low byte
// WRITE   | one-cycle memory write strobe, advance address
// CSUM    | waiting for checksum byte
// DONE    | frame loaded cleanly, cpu released
// ERROR   | checksum mismatch, cpu held in reset

module program_loader #(
    parameter int INST_SIZE = 16,
    parameter int ADDR_SIZE = 8,
    parameter int BYTE_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BYTE_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 start,
    output logic [INST_SIZE-1:0] mem_data,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_en_write,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_SIZE-1:0] loaded_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    logic [INST_SIZE-1:0] inst;
    logic [ADDR_SIZE-1:0] addr;
    logic [ADDR_SIZE-1:0] addr_inc;
    logic [ADDR_SIZE-1:0] count_n;
    logic [BYTE_SIZE-1:0] csum;
    logic                 accept;

    // Outputs decoded purely from the registered state.
    assign in_ready     = (state == S_IDLE) || (state == S_HI) ||
                          (state == S_LO)   || (state == S_CSUM);
    assign mem_en_write = (state == S_WRITE);
    assign done         = (state == S_DONE);
    assign error        = (state == S_ERROR);
    assign cpu_rst      = (state != S_DONE);

    assign accept   = in_valid && in_ready;
    assign addr_inc = addr + ADDR_SIZE'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (in_data == '0) ? S_CSUM : S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = (addr_inc == count_n) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == csum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst         <= '0;
            addr         <= '0;
            count_n      <= '0;
            csum         <= '0;
            mem_data     <= '0;
            mem_addr     <= '0;
            loaded_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count_n      <= ADDR_SIZE'(in_data);
                        csum         <= in_data;
                        addr         <= '0;
                        loaded_count <= '0;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        inst[INST_SIZE-1:BYTE_SIZE] <= in_data;
                        csum                        <= csum ^ in_data;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        inst[BYTE_SIZE-1:0] <= in_data;
                        csum                <= csum ^ in_data;
                        // Load the write port here so it is valid during the
                        // WRITE cycle and holds afterwards while inst is reused.
                        mem_data <= {inst[INST_SIZE-1:BYTE_SIZE], in_data};
                        mem_addr <= addr;
                    end
                end
                S_WRITE: begin
                    addr         <= addr_inc;
                    loaded_count <= loaded_count + ADDR_SIZE'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic [15:0] mem_data;
    logic [7:0]  mem_addr;
    logic        mem_en_write;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [7:0]  loaded_count;

    int tests_run = 0;
    int tests_failed = 0;
    int ready_in_write = 0;

    logic [7:0]  frame_q[$];
    logic [23:0] wr_q[$];
    logic [7:0]  last_n;

    program_loader #(.INST_SIZE(16), .ADDR_SIZE(8), .BYTE_SIZE(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .mem_data(mem_data),
        .mem_addr(mem_addr), .mem_en_write(mem_en_write), .cpu_rst(cpu_rst),
        .done(done), .error(error), .loaded_count(loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_en_write === 1'b1) begin
            wr_q.push_back({mem_addr, mem_data});
            if (in_ready !== 1'b0) ready_in_write++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int budget;
        if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        budget   = 0;
        do begin
            acc = in_ready;
            @(negedge clk);
            budget++;
        end while (!acc && budget < 60);
        check("byte_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic run_frame(input bit gaps, input bit start_in_hi);
        wr_q.delete();
        ready_in_write = 0;
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], gaps);
            if (i == 0 && start_in_hi) begin
                in_valid = 1'b0;
                start    = 1'b1;
                repeat (3) @(negedge clk);
                start = 1'b0;
                check("start_ignored_in_hi", {31'd0, in_ready}, 32'd1);
            end
        end
        in_valid = 1'b0;
    endtask

    // Reference: what a frame must produce, computed from the frame rules.
    task automatic check_frame(input string name);
        int n;
        logic [7:0] x;
        bit ok;
        n = frame_q[0];
        x = 8'h00;
        for (int i = 0; i <= 2 * n; i++) x ^= frame_q[i];
        ok = (frame_q[2 * n + 1] == x);
        check({name, ":write_count"}, wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++)
            check($sformatf("%s:write%0d", name, i), wr_q[i],
                  {8'(i), frame_q[1 + 2 * i], frame_q[2 + 2 * i]});
        check({name, ":done"}, {31'd0, done}, {31'd0, ok});
        check({name, ":error"}, {31'd0, error}, {31'd0, !ok});
        check({name, ":cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !ok});
        check({name, ":loaded_count"}, loaded_count, n);
        check({name, ":ready_low_in_write"}, ready_in_write, 0);
        check({name, ":strobe_idle"}, {31'd0, mem_en_write}, 32'd0);
        if (n > 0) check({name, ":addr_hold"}, mem_addr, n - 1);
        last_n = 8'(n);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start:cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("start:done", {31'd0, done}, 32'd0);
        check("start:error", {31'd0, error}, 32'd0);
        check("start:in_ready", {31'd0, in_ready}, 32'd1);
        check("start:count_held", loaded_count, last_n);
    endtask

    initial begin
        int n;
        logic [7:0] x;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        last_n = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("rst:in_ready", {31'd0, in_ready}, 32'd1);
        check("rst:mem_en_write", {31'd0, mem_en_write}, 32'd0);
        check("rst:mem_addr", mem_addr, 0);
        check("rst:mem_data", mem_data, 0);
        check("rst:cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst:done", {31'd0, done}, 32'd0);
        check("rst:error", {31'd0, error}, 32'd0);
        check("rst:loaded_count", loaded_count, 0);

        // Good two-instruction frame, in_valid held high throughout.
        frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(1'b0, 1'b0);
        check_frame("good2");

        // Bytes offered in DONE are never taken.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("done_hold:in_ready", {31'd0, in_ready}, 32'd0);
            check("done_hold:done", {31'd0, done}, 32'd1);
        end
        in_valid = 1'b0;
        check("done_hold:count", loaded_count, 2);

        pulse_start();
        frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_frame(1'b0, 1'b0);
        check_frame("bad_csum");
        pulse_start();
        frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(1'b0, 1'b0);
        check_frame("resend");

        pulse_start();
        frame_q = '{8'h00, 8'h00};
        run_frame(1'b0, 1'b0);
        check_frame("empty_ok");
        pulse_start();
        frame_q = '{8'h00, 8'h01};
        run_frame(1'b0, 1'b0);
        check_frame("empty_bad");

        pulse_start();
        frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(1'b1, 1'b0);
        check_frame("good2_gaps");

        pulse_start();
        frame_q = '{8'h01, 8'h12, 8'h34, 8'h27};
        run_frame(1'b0, 1'b1);
        check_frame("start_in_hi");

        // Reset mid-frame with a byte on offer: the byte must not be consumed.
        pulse_start();
        frame_q = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
        run_frame(1'b0, 1'b0);
        check("midframe:write", wr_q.size(), 1);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h07;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        check("midrst:in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst:cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("midrst:loaded_count", loaded_count, 0);
        check("midrst:mem_addr", mem_addr, 0);
        check("midrst:mem_data", mem_data, 0);
        frame_q = '{8'h01, 8'h55, 8'h66, 8'h32};
        run_frame(1'b0, 1'b0);
        check_frame("after_rst");

        for (int t = 0; t < 8; t++) begin
            pulse_start();
            n = $urandom_range(0, 6);
            frame_q.delete();
            frame_q.push_back(8'(n));
            x = 8'(n);
            for (int i = 0; i < 2 * n; i++) begin
                frame_q.push_back(8'($urandom));
                x ^= frame_q[$];
            end
            if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            frame_q.push_back(x);
            run_frame(1'b1, 1'b0);
            check_frame($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory. The cpu only ever reads instruction memory; this block fills it.
- Receives a framed byte stream (from a host or UART front-end) over a valid/ready handshake.
- Assembles INST_SIZE-bit instructions, writes them sequentially from address 0, and verifies a checksum.
- Holds the cpu in reset until a program has loaded cleanly.

Parameters:
INST_SIZE, 16, instruction width; must equal 2*BYTE_SIZE
ADDR_SIZE, 8, instruction memory address width; must be >= 8
BYTE_SIZE, 8, width of the input stream byte

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-low reset (0 = reset)
in_data  input  BYTE_SIZE  stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a byte this cycle
start  input  1  reload request; only honoured in DONE or ERROR
mem_data  output  INST_SIZE  instruction to write
mem_addr  output  ADDR_SIZE  write address
mem_en_write  output  1  one-cycle write strobe to instruction memory
cpu_rst  output  1  active-high reset for cpu; 1 while not DONE
done  output  1  program loaded and checksum matched
error  output  1  checksum mismatch
loaded_count  output  ADDR_SIZE  number of instructions written in current/last frame

Behaviour:
- Frame format: header byte N (instruction count, 0..255), then 2N bytes with the high byte of each instruction first, then a checksum byte.
- Checksum = XOR of the header and all 2N payload bytes.
- Transfer: a byte is accepted when in_valid && in_ready on a posedge. in_data is sampled only then.
- FSM states: IDLE, HI, LO, WRITE, CSUM, DONE, ERROR.
  - IDLE (in_ready=1): accept header; N saved; csum=header; addr=0. Next state is CSUM if N==0, else HI.
  - HI (in_ready=1): accept byte into inst[15:8]; csum ^= byte; go to LO.
  - LO (in_ready=1): accept byte into inst[7:0]; csum ^= byte; go to WRITE.
  - WRITE (in_ready=0): exactly one cycle. mem_en_write=1, mem_addr=addr, mem_data=inst. Then addr+1 and loaded_count+1. Go to CSUM if addr+1==N, else HI.
  - CSUM (in_ready=1): accept byte. Go to DONE if byte==csum, else ERROR.
  - DONE (in_ready=0): done=1, cpu_rst=0. If start=1, go to IDLE.
  - ERROR (in_ready=0): error=1, cpu_rst=1. If start=1, go to IDLE.
- Output decode: in_ready, cpu_rst, done and error are decoded from the registered state only. No combinational path from in_valid to in_ready.
- mem_en_write is 1 only in WRITE. mem_addr and mem_data hold their last written values otherwise.
- Idle states: with no accepted byte, HI/LO/CSUM/IDLE hold state. Gaps in in_valid are legal anywhere.
- start:
  - Ignored outside DONE/ERROR.
  - On IDLE entry from DONE/ERROR, the next cycle has cpu_rst=1, done=0, error=0, and loaded_count is cleared to 0 on the first accepted header.
- Address arithmetic: addr is ADDR_SIZE bits. N <= 255 guarantees no wrap at default width.
- Reset (rst=0 at posedge):
  - State goes to IDLE. in_ready=1, mem_en_write=0, mem_addr=0, mem_data=0, cpu_rst=1, done=0, error=0, loaded_count=0.
  - Inst, addr and csum are cleared.
  - Reset mid-frame abandons the frame. Memory contents already written are not cleared.
- Simultaneous rst=0 with start or in_valid: reset wins. No byte is consumed.
- Bytes presented in WRITE/DONE/ERROR are not consumed. The source must hold them; the loader never drops an accepted byte.

Test Plan:
1. Frame 0x02,0x12,0x34,0xAB,0xCD,0x42 -> writes 0x1234@0 then 0xABCD@1 (one-cycle strobes). Then done=1, cpu_rst=0, loaded_count=2, error=0.
2. Same frame with checksum 0x43 -> both writes occur, then error=1, done=0, cpu_rst=1. A start pulse -> IDLE with error=0; a re-sent correct frame reaches DONE.
3. Frame 0x00,0x00 -> no mem_en_write, done=1, loaded_count=0. Frame 0x00,0x01 -> ERROR.
4. in_valid held high continuously through case 1 -> in_ready=0 in each WRITE cycle, no byte lost or duplicated. Random in_valid gaps -> identical writes.
5. rst=0 after accepting 0x03,0xAA,0xBB,0xCC -> IDLE, cpu_rst=1. Then frame 0x01,0x55,0x66,0x32 -> write 0x5566@0, done=1.
6. In DONE, in_valid=1 with 0xFF for 10 cycles -> in_ready=0, no state change. start=1 during HI -> ignored.
